// File: rtl/res_matrix_drain_pkg.sv
// rtl/res_matrix_drain_pkg.sv - shared types and default sizes for the result matrix store, drain and multiplier
package res_matrix_drain_pkg;

    // Drain sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    // Default geometry shared by the store, the drain and the multiplier top
    localparam int M_DEF  = 2;
    localparam int DW_DEF = 8;
    localparam int RW_DEF = 3 * DW_DEF;
    localparam int CW_DEF = 8;

endpackage

// File: rtl/res_matrix_addr_gen.sv
// rtl/res_matrix_addr_gen.sv - row-major row/col walker that parks on the last element
module res_matrix_addr_gen
    import res_matrix_drain_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [DW-1:0] row,
    output logic [DW-1:0] col,
    output logic          is_last
);

    localparam logic [DW-1:0] LAST = DW'(M - 1);
    localparam logic [DW-1:0] ONE  = DW'(1);

    logic [DW-1:0] row_q, row_d;
    logic [DW-1:0] col_q, col_d;

    assign is_last = (row_q == LAST) && (col_q == LAST);
    assign row     = row_q;
    assign col     = col_q;

    // Next address: clear wins, otherwise step col then row, never past the last element
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance && !is_last) begin
            if (col_q == LAST) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
        end
    end

    // Address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/res_matrix_drain.sv
// rtl/res_matrix_drain.sv - streams the M x M result matrix out row-major with overflow tagging
module res_matrix_drain
    import res_matrix_drain_pkg::*;
#(
    parameter int M   = M_DEF,
    parameter int DW  = DW_DEF,
    parameter int RW  = 3 * DW,
    parameter int SAT = 0,
    parameter int CW  = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    rowSel,
    output logic [DW-1:0]    colSel,
    input  logic [DW-1:0]    memData,
    input  logic [RW-DW-1:0] memOf,
    output logic             outValid,
    input  logic             outReady,
    output logic [DW-1:0]    outData,
    output logic             outOvf,
    output logic [DW-1:0]    outRow,
    output logic [DW-1:0]    outCol,
    output logic             outLast,
    output logic [CW-1:0]    ovfCount
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    drain_state_e state_q, state_d;

    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_ovf_q, out_ovf_d;
    logic [DW-1:0] out_row_q, out_row_d;
    logic [DW-1:0] out_col_q, out_col_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] ovf_count_q, ovf_count_d;

    logic          addr_clear;
    logic          capture;
    logic [DW-1:0] cur_row;
    logic [DW-1:0] cur_col;
    logic          cur_is_last;
    logic          mem_ovf;
    logic [DW-1:0] cap_data;

    res_matrix_addr_gen #(
        .M  (M),
        .DW (DW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst),
        .clear   (addr_clear),
        .advance (capture),
        .row     (cur_row),
        .col     (cur_col),
        .is_last (cur_is_last)
    );

    assign mem_ovf  = |memOf;
    assign cap_data = ((SAT != 0) && mem_ovf) ? {DW{1'b1}} : memData;

    // Sequencer and output-register next state; a capture loads the element at the current address and steps it
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        ovf_count_d = ovf_count_q;
        addr_clear  = 1'b0;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = FETCH;
                    addr_clear  = 1'b1;
                    ovf_count_d = '0;
                    busy_d      = 1'b1;
                end
            end
            FETCH: begin
                capture = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (out_valid_q && outReady) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            out_valid_d = 1'b1;
            out_data_d  = cap_data;
            out_ovf_d   = mem_ovf;
            out_row_d   = cur_row;
            out_col_d   = cur_col;
            out_last_d  = cur_is_last;
            if (mem_ovf && (ovf_count_q != {CW{1'b1}})) begin
                ovf_count_d = ovf_count_q + CNT_ONE;
            end
        end
    end

    // State and output registers; reset aborts a pass and clears every output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rowSel   = cur_row;
    assign colSel   = cur_col;
    assign outValid = out_valid_q;
    assign outData  = out_data_q;
    assign outOvf   = out_ovf_q;
    assign outRow   = out_row_q;
    assign outCol   = out_col_q;
    assign outLast  = out_last_q;
    assign ovfCount = ovf_count_q;

endmodule

// File: tb/tb_res_matrix_drain.sv
// tb/tb_res_matrix_drain.sv - self-checking bench for res_matrix_drain (raw and saturating instances)
module tb_res_matrix_drain;

    localparam int M  = 2;
    localparam int DW = 8;
    localparam int RW = 24;
    localparam int OW = RW - DW;
    localparam int CW = 8;
    localparam int AW = 2;

    typedef struct packed {
        logic [DW-1:0] row;
        logic [DW-1:0] col;
        logic [DW-1:0] data;
        logic [DW-1:0] sdata;
        logic          ovf;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    logic [RW-1:0] store [M*M];

    logic          busy0, done0, ov0, oo0, ol0;
    logic [DW-1:0] rs0, cs0, md0, od0, or0, oc0;
    logic [OW-1:0] mo0;
    logic [CW-1:0] cnt0;
    logic [AW-1:0] idx0;
    logic          busy1, done1, ov1, oo1, ol1;
    logic [DW-1:0] rs1, cs1, md1, od1, or1, oc1;
    logic [OW-1:0] mo1;
    logic [CW-1:0] cnt1;
    logic [AW-1:0] idx1;

    assign idx0 = AW'(rs0 * DW'(M) + cs0);
    assign idx1 = AW'(rs1 * DW'(M) + cs1);
    assign {mo0, md0} = store[idx0];
    assign {mo1, md1} = store[idx1];

    res_matrix_drain #(.M(M), .DW(DW), .RW(RW), .SAT(0), .CW(CW)) dut_raw (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .rowSel(rs0), .colSel(cs0), .memData(md0), .memOf(mo0),
        .outValid(ov0), .outReady(out_ready), .outData(od0), .outOvf(oo0),
        .outRow(or0), .outCol(oc0), .outLast(ol0), .ovfCount(cnt0)
    );

    res_matrix_drain #(.M(M), .DW(DW), .RW(RW), .SAT(1), .CW(CW)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .rowSel(rs1), .colSel(cs1), .memData(md1), .memOf(mo1),
        .outValid(ov1), .outReady(out_ready), .outData(od1), .outOvf(oo1),
        .outRow(or1), .outCol(oc1), .outLast(ol1), .ovfCount(cnt1)
    );

    int n_pass = 0;
    int n_total = 0;
    beat_t got [$];
    beat_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.row = or0; b.col = oc0; b.data = od0; b.sdata = od1; b.ovf = oo0; b.last = ol0;
        return b;
    endfunction

    function automatic logic [63:0] outs_raw();
        return 64'({busy0, done0, ov0, oo0, ol0, rs0, cs0, od0, or0, oc0, cnt0});
    endfunction

    function automatic logic [63:0] outs_sat();
        return 64'({busy1, done1, ov1, oo1, ol1, rs1, cs1, od1, or1, oc1, cnt1});
    endfunction

    // Reference: walk the store row-major, tag overflow, saturate for the SAT=1 copy, count overflows
    task automatic compare_model(input string tag);
        beat_t exp_q [$];
        int nov = 0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                logic [RW-1:0] w;
                beat_t b;
                w = store[r*M + c];
                b.row = DW'(r);
                b.col = DW'(c);
                b.data = w[DW-1:0];
                b.ovf = (w[RW-1:DW] != 0);
                b.sdata = b.ovf ? {DW{1'b1}} : w[DW-1:0];
                b.last = (r == M-1) && (c == M-1);
                if (b.ovf) nov++;
                exp_q.push_back(b);
            end
        end
        if (nov > 255) nov = 255;
        check({tag, "_beat_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        check({tag, "_ovfcount_raw"}, 64'(cnt0), 64'(nov));
        check({tag, "_ovfcount_sat"}, 64'(cnt1), 64'(nov));
    endtask

    // One drain pass: mode 0 ready high, 1 fixed stall pattern, 2 random; spam holds start high; abort_after>0 resets after that many beats
    task automatic run_pass(input int mode, input bit spam, input int abort_after, output int lat);
        beat_t snap;
        bit stalled = 1'b0;
        bit finished = 1'b0;
        int dones = 0;
        got.delete();
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 300 && !finished; k++) begin
            @(negedge clk);
            start = spam;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (((k - 1) % 6) inside {0, 3, 5});
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (k == 1) begin
                check("busy_after_start", 64'(busy0), 64'd1);
                check("no_valid_in_fetch", 64'(ov0), 64'd0);
            end
            if (stalled) check($sformatf("stall_hold_k%0d", k), 64'(cur_beat()), 64'(snap));
            stalled = ov0 && !out_ready;
            snap = cur_beat();
            if (ov0 && out_ready) got.push_back(cur_beat());
            if (done0) begin
                dones++;
                lat = k - 1;
                start = 1'b0;
                check("busy_low_with_done", 64'(busy0), 64'd0);
            end else if (dones > 0) begin
                finished = 1'b1;
            end
            if (abort_after > 0 && got.size() == abort_after && ov0 && out_ready) begin
                @(posedge clk);
                #2;
                check("valid_before_abort", 64'(ov0), 64'd1);
                rst = 1'b0;
                #1;
                check("abort_valid_drop_raw", 64'(ov0), 64'd0);
                check("abort_valid_drop_sat", 64'(ov1), 64'd0);
                start = 1'b0;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (done0 || done1) dones++;
                end
                rst = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    if (done0 || done1) dones++;
                end
                finished = 1'b1;
            end
        end
        start = 1'b0;
        check("pass_terminated", 64'(finished), 64'd1);
        check("done_pulses", 64'(dones), (abort_after > 0) ? 64'd0 : 64'd1);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_no_restart", 64'({ov0, busy0, ov1, busy1}), 64'd0);
        end
    endtask

    initial begin
        int lat;
        tbl[0] = '{row: 8'd0, col: 8'd0, data: 8'h05, sdata: 8'h05, ovf: 1'b0, last: 1'b0};
        tbl[1] = '{row: 8'd0, col: 8'd1, data: 8'hFF, sdata: 8'hFF, ovf: 1'b1, last: 1'b0};
        tbl[2] = '{row: 8'd1, col: 8'd0, data: 8'h00, sdata: 8'h00, ovf: 1'b0, last: 1'b0};
        tbl[3] = '{row: 8'd1, col: 8'd1, data: 8'hFF, sdata: 8'hFF, ovf: 1'b0, last: 1'b1};
        tbl[4] = tbl[0];
        tbl[5] = '{row: 8'd0, col: 8'd1, data: 8'h34, sdata: 8'hFF, ovf: 1'b1, last: 1'b0};
        tbl[6] = tbl[2];
        tbl[7] = tbl[3];

        store[0] = 24'h000005;
        store[1] = 24'h0001FF;
        store[2] = 24'h000000;
        store[3] = 24'h0000FF;

        repeat (3) @(negedge clk);
        check("reset_outputs_raw", outs_raw(), 64'd0);
        check("reset_outputs_sat", outs_sat(), 64'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_outputs_raw", outs_raw(), 64'd0);
        check("idle_outputs_sat", outs_sat(), 64'd0);

        run_pass(0, 1'b0, 0, lat);
        check("done_latency", 64'(lat), 64'(M*M + 2));
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check($sformatf("table_base_%0d", i), 64'(got[i]), 64'(tbl[i]));
        compare_model("base");

        store[1] = 24'h000134;
        run_pass(0, 1'b0, 0, lat);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check($sformatf("table_0134_%0d", i), 64'(got[i]), 64'(tbl[4 + i]));
        compare_model("v0134");
        store[1] = 24'h0001FF;

        run_pass(1, 1'b0, 0, lat);
        compare_model("stall");

        run_pass(0, 1'b1, 0, lat);
        compare_model("start_spam");
        idle_check(4);

        run_pass(0, 1'b0, 2, lat);
        check("abort_beats", 64'(got.size()), 64'd2);
        check("abort_outputs_cleared", outs_raw(), 64'd0);
        run_pass(0, 1'b0, 0, lat);
        compare_model("after_abort");

        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < M*M; i++) begin
                store[i] = RW'($urandom);
                if ($urandom_range(0, 1) == 1) store[i][RW-1:DW] = '0;
            end
            run_pass(2, 1'b0, 0, lat);
            compare_model($sformatf("rand%0d", p));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
